// File: rtl/fetch_control_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decode-side
// instruction buffer, branch redirect inputs and halt status.
// The master side is the fetch unit and the slave side is its environment.
interface fetch_control_if;
  // Instruction memory request and response
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Instruction buffer handed to decode
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  // Redirect from the branch condition unit
  logic        br_taken;
  logic [31:0] br_target;

  // Halt status
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] fault_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output if_valid, if_pc, if_instr,
    input  if_ready,
    input  br_taken, br_target,
    output halted, halt_cause, fault_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  if_valid, if_pc, if_instr,
    output if_ready,
    output br_taken, br_target,
    input  halted, halt_cause, fault_pc
  );
endinterface

// File: rtl/fetch_control.sv
// Instruction fetch sequencer. Owns the PC, keeps at most one instruction
// memory request outstanding, buffers one instruction for decode, applies
// branch redirects (discarding a response that is already in flight) and
// halts on a misaligned redirect target or a memory response timeout.
module fetch_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_control_if.master bus
);

  // Wait counter wide enough to hold TIMEOUT-1; a TIMEOUT of 0 disables the check.
  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,   // first cycle out of reset
    S_REQ,    // presenting a request for pc
    S_RESP,   // waiting for the response to pc
    S_DROP,   // waiting for a response that a redirect made stale
    S_HALT    // stopped until reset
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } cause_e;

  state_e           state_q;
  cause_e           cause_q;
  logic [31:0]      pc_q;
  logic [31:0]      if_pc_q;
  logic [31:0]      if_instr_q;
  logic [31:0]      fault_pc_q;
  logic             if_valid_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic req;
  logic accept;
  logic redirect;
  logic misaligned;
  logic timeout_hit;

  // A request goes out only when the buffer is empty or is being drained this
  // cycle, so a returning instruction always finds room; this keeps the
  // REQ/RESP pair at one instruction every two cycles with a fast memory.
  assign req         = (state_q == S_REQ) && (!if_valid_q || bus.if_ready);
  assign accept      = req && bus.imem_ready;
  assign redirect    = bus.br_taken &&
                       ((state_q == S_REQ) || (state_q == S_RESP) || (state_q == S_DROP));
  assign misaligned  = (bus.br_target[1:0] != 2'b00);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Fetch FSM: sequences requests, loads the decode buffer and records halts.
  // NOTE: state is updated with non-blocking assignments only, so every test
  //       below sees pre-edge values and a later assignment in the block
  //       (e.g. a redirect clearing if_valid_q) cleanly overrides the default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cause_q    <= CAUSE_NONE;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      fault_pc_q <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // Decode takes the buffered instruction.
      if (if_valid_q && bus.if_ready) begin
        if_valid_q <= 1'b0;
      end

      if (redirect) begin
        // Redirect wins over every other event and always squashes the buffer.
        if_valid_q <= 1'b0;
        if (misaligned) begin
          state_q    <= S_HALT;
          halted_q   <= 1'b1;
          cause_q    <= CAUSE_MISALIGN;
          fault_pc_q <= bus.br_target;
        end else begin
          pc_q  <= bus.br_target;
          // The timeout window restarts for whatever request is still in flight.
          cnt_q <= '0;
          case (state_q)
            S_REQ:   state_q <= accept ? S_DROP : S_REQ;
            // RESP or DROP: a response arriving now is simply discarded.
            default: state_q <= bus.imem_rvalid ? S_REQ : S_DROP;
          endcase
        end
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_REQ;

          S_REQ: begin
            if (accept) begin
              state_q <= S_RESP;
              cnt_q   <= '0;
            end
          end

          S_RESP, S_DROP: begin
            if (bus.imem_rvalid) begin
              state_q <= S_REQ;
              // Only a live response fills the buffer; a stale one is dropped.
              if (state_q == S_RESP) begin
                if_valid_q <= 1'b1;
                if_pc_q    <= pc_q;
                if_instr_q <= bus.imem_rdata;
                pc_q       <= pc_q + 32'd4;
              end
            end else if (timeout_hit) begin
              state_q    <= S_HALT;
              halted_q   <= 1'b1;
              cause_q    <= CAUSE_TIMEOUT;
              fault_pc_q <= pc_q;
              if_valid_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          // S_HALT: redirects and responses are ignored until reset.
          default: ;
        endcase
      end
    end
  end

  // Outputs: everything but the request strobe comes straight from registers.
  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_pc      = if_pc_q;
  assign bus.if_instr   = if_instr_q;
  assign bus.halted     = halted_q;
  assign bus.halt_cause = cause_q;
  assign bus.fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: directed steps for reset, streaming, decode
// back-pressure, redirects, misaligned halt, timeout halt and async reset,
// then a randomized phase scored against an instruction-stream model.
module tb_fetch_control;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fetch_control_if bus ();

  fetch_control #(
    .RESET_PC(RST_PC),
    .TIMEOUT (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the memory model returns for a given address.
  function automatic logic [31:0] f_instr(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled around the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // NOTE: stimulus uses blocking assignments from the initial block so that
  //       values are settled well before the DUT samples them on posedge.
  task automatic drive_idle();
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.if_ready    = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = '0;
  endtask

  // Assert reset, check every output without any clock edge, release on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_imem_req",   bus.imem_req,   0);
    check("rst_imem_addr",  bus.imem_addr,  RST_PC);
    check("rst_if_valid",   bus.if_valid,   0);
    check("rst_if_pc",      bus.if_pc,      0);
    check("rst_if_instr",   bus.if_instr,   0);
    check("rst_halted",     bus.halted,     0);
    check("rst_halt_cause", bus.halt_cause, 0);
    check("rst_fault_pc",   bus.fault_pc,   0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic [31:0] pend_addr;
    logic        br;
    logic        hold;
    logic        pend;
    logic        acc;
    int          wait_n;
    int          n_xfer;

    rst_n = 1'b1;
    drive_idle();
    #2;

    // ---- Reset values, then IDLE issues nothing ----
    do_reset();
    #1;
    check("idle_no_req", bus.imem_req, 0);
    tick();

    // ---- Streaming with one-cycle memory latency and decode always ready ----
    bus.if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = RST_PC + 32'(4 * k);
      bus.imem_ready = 1'b1;
      #1;
      check("t1_req",  bus.imem_req,  1);
      check("t1_addr", bus.imem_addr, a);
      tick();
      bus.imem_ready  = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = f_instr(a);
      #1;
      check("t1_req_in_resp", bus.imem_req, 0);
      tick();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      #1;
      check("t1_valid", bus.if_valid, 1);
      check("t1_pc",    bus.if_pc,    a);
      check("t1_instr", bus.if_instr, f_instr(a));
    end

    // ---- Decode back-pressure holds the buffer and blocks requests ----
    bus.if_ready   = 1'b0;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_no_req",    bus.imem_req, 0);
      check("t2_valid",     bus.if_valid, 1);
      check("t2_pc_stable", bus.if_pc,    32'h108);
      tick();
    end
    bus.if_ready = 1'b1;
    #1;
    check("t2_req_same_cycle", bus.imem_req,  1);
    check("t2_addr",           bus.imem_addr, 32'h10C);
    tick();

    // ---- Redirect while waiting: late response is discarded ----
    bus.imem_ready = 1'b0;
    bus.br_taken   = 1'b1;
    bus.br_target  = 32'h200;
    tick();
    bus.br_taken = 1'b0;
    #1;
    check("t3_drop_no_req", bus.imem_req, 0);
    check("t3_drop_empty",  bus.if_valid, 0);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_ready  = 1'b1;
    #1;
    check("t3_stale_discarded", bus.if_valid,  0);
    check("t3_req",             bus.imem_req,  1);
    check("t3_addr",            bus.imem_addr, 32'h200);
    tick();
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = f_instr(32'h200);
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    check("t3_valid", bus.if_valid, 1);
    check("t3_pc",    bus.if_pc,    32'h200);
    check("t3_instr", bus.if_instr, f_instr(32'h200));

    // ---- Redirect and response in the same cycle: response squashed ----
    bus.imem_ready = 1'b1;
    #1;
    check("t4_addr_seq", bus.imem_addr, 32'h204);
    tick();
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = f_instr(32'h204);
    bus.br_taken    = 1'b1;
    bus.br_target   = 32'h300;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.br_taken    = 1'b0;
    #1;
    check("t4_squash",  bus.if_valid,  0);
    check("t4_req",     bus.imem_req,  1);
    check("t4_addr",    bus.imem_addr, 32'h300);
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = f_instr(32'h300);
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    check("t4_buf_pc", bus.if_pc, 32'h300);
    // Redirect with a full buffer and decode ready: buffer still squashed.
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h400;
    tick();
    bus.br_taken = 1'b0;
    #1;
    check("t4_squash_ready", bus.if_valid,  0);
    check("t4_req_400",      bus.imem_req,  1);
    check("t4_addr_400",     bus.imem_addr, 32'h400);
    // Redirect in the cycle a request is accepted: its response is dropped.
    bus.imem_ready = 1'b1;
    bus.br_taken   = 1'b1;
    bus.br_target  = 32'h500;
    tick();
    bus.imem_ready = 1'b0;
    bus.br_taken   = 1'b0;
    #1;
    check("t4_drop_no_req", bus.imem_req, 0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = f_instr(32'h400);
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    check("t4_drop_discard", bus.if_valid,  0);
    check("t4_addr_500",     bus.imem_addr, 32'h500);
    check("t4_req_500",      bus.imem_req,  1);

    // ---- Misaligned redirect target halts until reset ----
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h202;
    tick();
    bus.br_taken = 1'b0;
    #1;
    check("t5_halted",   bus.halted,     1);
    check("t5_cause",    bus.halt_cause, 1);
    check("t5_fault_pc", bus.fault_pc,   32'h202);
    check("t5_no_req",   bus.imem_req,   0);
    check("t5_empty",    bus.if_valid,   0);
    bus.br_taken    = 1'b1;
    bus.br_target   = 32'h600;
    bus.imem_rvalid = 1'b1;
    bus.imem_ready  = 1'b1;
    bus.imem_rdata  = 32'h1234_5678;
    ticks(3);
    #1;
    check("t5_sticky_halted", bus.halted,     1);
    check("t5_sticky_cause",  bus.halt_cause, 1);
    check("t5_sticky_fault",  bus.fault_pc,   32'h202);
    check("t5_sticky_no_req", bus.imem_req,   0);
    check("t5_sticky_empty",  bus.if_valid,   0);
    check("t5_pc_frozen",     bus.imem_addr,  32'h500);
    drive_idle();
    do_reset();

    // ---- Response on the last allowed cycle does not halt ----
    bus.if_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    ticks(7);
    #1;
    check("t6_wait7_running", bus.halted, 0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = f_instr(RST_PC);
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    check("t6_late_ok_halted", bus.halted,   0);
    check("t6_late_ok_valid",  bus.if_valid, 1);
    check("t6_late_ok_pc",     bus.if_pc,    RST_PC);
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    ticks(4);
    #1;
    check("t6_mid_addr", bus.imem_addr, RST_PC + 32'd4);
    check("t6_mid_pc",   bus.if_pc,     RST_PC);
    // Reset dropped between clock edges while waiting for a response.
    #1;
    do_reset();

    // ---- No response: halt after eight waiting cycles ----
    tick();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    ticks(7);
    #1;
    check("t6_7_cycles_running", bus.halted, 0);
    tick();
    #1;
    check("t6_timeout_halted", bus.halted,     1);
    check("t6_timeout_cause",  bus.halt_cause, 2);
    check("t6_timeout_fault",  bus.fault_pc,   RST_PC);
    check("t6_timeout_no_req", bus.imem_req,   0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = f_instr(RST_PC);
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    check("t6_halt_ignores_rvalid", bus.if_valid,   0);
    check("t6_halt_cause_kept",     bus.halt_cause, 2);
    drive_idle();
    do_reset();

    // ---- Randomized traffic against an instruction-stream model ----
    // Decode must see RESET_PC, +4, +8 ... restarting at each redirect target,
    // each carrying the memory's word for that address; a stalled buffer must
    // not change.
    exp_pc     = RST_PC;
    pend       = 1'b0;
    pend_addr  = '0;
    wait_n     = 0;
    hold       = 1'b0;
    hold_pc    = '0;
    hold_instr = '0;
    n_xfer     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      br  = (cyc != 0) && ($urandom_range(0, 15) == 0);
      tgt = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      bus.br_taken    = br;
      bus.br_target   = tgt;
      bus.if_ready    = ($urandom_range(0, 3) != 0);
      bus.imem_ready  = ($urandom_range(0, 2) != 0);
      bus.imem_rvalid = pend && (wait_n == 0);
      bus.imem_rdata  = (pend && (wait_n == 0)) ? f_instr(pend_addr) : $urandom();
      #1;
      if (hold) begin
        check("rnd_hold_valid", bus.if_valid, 1);
        check("rnd_hold_pc",    bus.if_pc,    hold_pc);
        check("rnd_hold_instr", bus.if_instr, hold_instr);
      end
      hold = 1'b0;
      if (br) begin
        exp_pc = tgt;
      end else if (bus.if_valid && bus.if_ready) begin
        check("rnd_xfer_pc",    bus.if_pc,    exp_pc);
        check("rnd_xfer_instr", bus.if_instr, f_instr(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end else if (bus.if_valid) begin
        hold       = 1'b1;
        hold_pc    = bus.if_pc;
        hold_instr = bus.if_instr;
      end
      acc = bus.imem_req && bus.imem_ready;
      if (bus.imem_rvalid) pend = 1'b0;
      else if (pend) wait_n--;
      if (acc) begin
        pend      = 1'b1;
        wait_n    = $urandom_range(0, 4);
        pend_addr = bus.imem_addr;
      end
      tick();
    end
    check("rnd_min_transfers", 32'(n_xfer >= 150), 1);
    check("rnd_never_halted",  bus.halted,         0);

    drive_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
